// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared types, S-box table and Rcon lookup for the AES-128 key sequencer
package aes_key_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_STREAM
    } seq_state_e;

    typedef enum logic {
        DIR_FWD,
        DIR_INV
    } step_dir_e;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_dec_key_sequencer_if.sv
// rtl/aes_dec_key_sequencer_if.sv - key load and round-key stream handshake bundle
interface aes_dec_key_sequencer_if;
    import aes_key_pkg::*;

    logic       key_valid;
    logic       key_ready;
    aes_key_t   cipher_key;
    logic       replay;
    logic       rk_valid;
    logic       rk_ready;
    aes_key_t   rk_data;
    logic [3:0] rk_round;

    modport master (
        output key_valid, cipher_key, replay, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_round
    );

    modport slave (
        input  key_valid, cipher_key, replay, rk_ready,
        output key_ready, rk_valid, rk_data, rk_round
    );

endinterface

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one AES-128 key schedule step, forward or inverse, sharing one SubWord
module aes_key_step
    import aes_key_pkg::*;
(
    input  step_dir_e  dir,
    input  logic [3:0] round,
    input  aes_key_t   key_in,
    output aes_key_t   key_out
);

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p1, p2, p3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] sbox_in, t;

    always_comb begin
        k0 = key_in[127:96];
        k1 = key_in[95:64];
        k2 = key_in[63:32];
        k3 = key_in[31:0];
        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        // The inverse step recovers the previous word 3 first, so it feeds the S-boxes instead of k3.
        sbox_in = (dir == DIR_INV) ? p3 : k3;
        t  = sub_word({sbox_in[23:0], sbox_in[31:24]}) ^ {rcon(round), 24'h0};
        n0 = k0 ^ t;
        n1 = k1 ^ n0;
        n2 = k2 ^ n1;
        n3 = k3 ^ n2;
        if (dir == DIR_INV) begin
            key_out = {n0, p1, p2, p3};
        end else begin
            key_out = {n0, n1, n2, n3};
        end
    end

endmodule

// File: rtl/aes_dec_key_sequencer.sv
// rtl/aes_dec_key_sequencer.sv - expands an AES-128 key to round 10 and streams round keys 10..0
module aes_dec_key_sequencer
    import aes_key_pkg::*;
#(
    parameter int unsigned ENABLE_CACHE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_dec_key_sequencer_if.slave  bus,
    output logic                    cache_valid,
    output logic                    busy,
    output logic                    done
);

    seq_state_e state, state_next;
    aes_key_t   key_reg, key_next, cache_key, step_out;
    logic [3:0] round, round_next, round_inc, step_round;
    logic       cache_flag, cache_load, done_reg, done_next;
    step_dir_e  step_dir;

    assign round_inc  = round + 4'd1;
    assign step_dir   = (state == ST_STREAM) ? DIR_INV : DIR_FWD;
    assign step_round = (state == ST_STREAM) ? round : round_inc;

    aes_key_step u_step (
        .dir     (step_dir),
        .round   (step_round),
        .key_in  (key_reg),
        .key_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            key_reg    <= '0;
            round      <= 4'd0;
            cache_key  <= '0;
            cache_flag <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state    <= state_next;
            key_reg  <= key_next;
            round    <= round_next;
            done_reg <= done_next;
            if (cache_load) begin
                cache_key  <= key_next;
                cache_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        key_next   = key_reg;
        round_next = round;
        cache_load = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A fresh key takes priority over replaying the cached one.
                if (bus.key_valid) begin
                    key_next   = bus.cipher_key;
                    round_next = 4'd0;
                    state_next = ST_EXPAND;
                end else if (bus.replay && cache_flag && (ENABLE_CACHE != 0)) begin
                    key_next   = cache_key;
                    round_next = 4'(NUM_ROUNDS);
                    state_next = ST_STREAM;
                end
            end
            ST_EXPAND: begin
                key_next   = step_out;
                round_next = round_inc;
                if (round_inc == 4'(NUM_ROUNDS)) begin
                    cache_load = (ENABLE_CACHE != 0);
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (bus.rk_ready) begin
                    if (round == 4'd0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        key_next   = step_out;
                        round_next = round - 4'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.key_ready = (state == ST_IDLE);
    assign bus.rk_valid  = (state == ST_STREAM);
    assign bus.rk_data   = (state == ST_STREAM) ? key_reg : '0;
    assign bus.rk_round  = (state == ST_STREAM) ? round : 4'd0;
    assign busy          = (state != ST_IDLE);
    assign done          = done_reg;
    assign cache_valid   = cache_flag;

endmodule

// File: tb/tb_aes_dec_key_sequencer.sv
// tb/tb_aes_dec_key_sequencer.sv - randomized self-checking bench against a word-level AES key schedule model
module tb_aes_dec_key_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_dec_key_sequencer_if kif ();
    aes_dec_key_sequencer_if kif_nc ();
    logic cache_valid, busy, done;
    logic cache_valid_nc, busy_nc, done_nc;

    aes_dec_key_sequencer #(.ENABLE_CACHE(1)) dut (
        .clk(clk), .rst(rst), .bus(kif),
        .cache_valid(cache_valid), .busy(busy), .done(done)
    );

    aes_dec_key_sequencer #(.ENABLE_CACHE(0)) dut_nc (
        .clk(clk), .rst(rst), .bus(kif_nc),
        .cache_valid(cache_valid_nc), .busy(busy_nc), .done(done_nc)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]   ref_sbox [256];
    logic [127:0] exp_rk [11];
    logic [127:0] cap_d [$];
    logic [3:0]   cap_r [$];
    int cap_unstable, cap_dones;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic init_ref_sbox();
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            ref_sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key(input logic [127:0] k, input logic with_replay);
        kif.cipher_key = k;
        kif.key_valid  = 1'b1;
        kif.replay     = with_replay;
        tick();
        kif.key_valid  = 1'b0;
        kif.replay     = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!kif.rk_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    // Drains the stream into cap_d/cap_r; optionally pokes key_valid/replay the whole time.
    task automatic collect(input int stall_pct, input int stop_at, input bit inject, input logic [127:0] inj_key);
        logic [127:0] hd = '0;
        logic [3:0]   hr = 4'd0;
        bit held = 0;
        bit fin  = 0;
        int cyc  = 0;
        cap_d.delete();
        cap_r.delete();
        cap_unstable = 0;
        cap_dones = 0;
        kif.cipher_key = inj_key;
        while (!fin && cyc < 300 && !(kif.rk_valid && int'(kif.rk_round) == stop_at)) begin
            bit acc;
            if (held && (kif.rk_valid !== 1'b1 || kif.rk_data !== hd || kif.rk_round !== hr)) cap_unstable++;
            kif.rk_ready = ($urandom_range(0, 99) >= stall_pct);
            acc = kif.rk_valid && kif.rk_ready;
            held = 0;
            if (acc) begin
                cap_d.push_back(kif.rk_data);
                cap_r.push_back(kif.rk_round);
                if (kif.rk_round == 4'd0) fin = 1;
            end else if (kif.rk_valid) begin
                held = 1;
                hd = kif.rk_data;
                hr = kif.rk_round;
            end
            kif.key_valid = inject && !fin;
            kif.replay    = inject && !fin;
            tick();
            cyc++;
            if (done) cap_dones++;
        end
        kif.rk_ready  = 1'b0;
        kif.key_valid = 1'b0;
        kif.replay    = 1'b0;
        if (fin) begin
            tick();
            if (done) cap_dones++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++; if (kif.key_ready !== 1'b1) begin n_err++; $display("FAIL reset_key_ready got %b want 1", kif.key_ready); end
        n_cmp++; if (kif.rk_valid !== 1'b0) begin n_err++; $display("FAIL reset_rk_valid got %b want 0", kif.rk_valid); end
        n_cmp++; if (kif.rk_data !== 128'h0) begin n_err++; $display("FAIL reset_rk_data got %h want 0", kif.rk_data); end
        n_cmp++; if (kif.rk_round !== 4'd0) begin n_err++; $display("FAIL reset_rk_round got %0d want 0", kif.rk_round); end
        n_cmp++; if ({busy, done, cache_valid} !== 3'b000) begin n_err++; $display("FAIL reset_busy_done_cache got %b want 000", {busy, done, cache_valid}); end
        kif.replay = 1'b1;
        tick();
        kif.replay = 1'b0;
        n_cmp++; if (kif.rk_valid !== 1'b0 || kif.key_ready !== 1'b1) begin n_err++; $display("FAIL replay_no_cache got valid %b ready %b want 0 1", kif.rk_valid, kif.key_ready); end
    endtask

    task automatic test_fips();
        int e;
        model_expand(FIPS_KEY);
        load_key(FIPS_KEY, 1'b0);
        wait_valid(e);
        n_cmp++; if (e != 10) begin n_err++; $display("FAIL fips_latency got %0d edges after accept want 10", e); end
        n_cmp++; if (kif.rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || kif.rk_round !== 4'd10) begin n_err++; $display("FAIL fips_round10 got %0d %h want 10 d014f9a8c9ee2589e13f0cc8b6630ca6", kif.rk_round, kif.rk_data); end
        collect(0, -1, 0, '0);
        n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL fips_count got %0d want 11", cap_d.size()); end
        for (int i = 0; i < cap_d.size() && i < 11; i++) begin
            n_cmp++; if (cap_d[i] !== exp_rk[10-i] || cap_r[i] !== 4'(10-i)) begin n_err++; $display("FAIL fips_stream[%0d] got %0d %h want %0d %h", i, cap_r[i], cap_d[i], 10-i, exp_rk[10-i]); end
        end
        if (cap_d.size() == 11) begin
            n_cmp++; if (cap_d[9] !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_err++; $display("FAIL fips_round1 got %h want a0fafe1788542cb123a339392a6c7605", cap_d[9]); end
            n_cmp++; if (cap_d[10] !== FIPS_KEY) begin n_err++; $display("FAIL fips_round0 got %h want %h", cap_d[10], FIPS_KEY); end
        end
        n_cmp++; if (cap_dones != 1) begin n_err++; $display("FAIL fips_done got %0d pulses want 1", cap_dones); end
        n_cmp++; if ({busy, kif.key_ready, cache_valid} !== 3'b011) begin n_err++; $display("FAIL fips_idle got busy/ready/cache %b want 011", {busy, kif.key_ready, cache_valid}); end
    endtask

    task automatic test_stall();
        int e;
        model_expand(FIPS_KEY);
        load_key(FIPS_KEY, 1'b0);
        wait_valid(e);
        collect(50, -1, 0, '0);
        n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL stall_count got %0d want 11", cap_d.size()); end
        for (int i = 0; i < cap_d.size() && i < 11; i++) begin
            n_cmp++; if (cap_d[i] !== exp_rk[10-i] || cap_r[i] !== 4'(10-i)) begin n_err++; $display("FAIL stall_stream[%0d] got %0d %h want %0d %h", i, cap_r[i], cap_d[i], 10-i, exp_rk[10-i]); end
        end
        n_cmp++; if (cap_unstable != 0) begin n_err++; $display("FAIL stall_hold got %0d unstable cycles want 0", cap_unstable); end
        n_cmp++; if (cap_dones != 1) begin n_err++; $display("FAIL stall_done got %0d pulses want 1", cap_dones); end
    endtask

    task automatic test_replay();
        int w;
        kif.replay = 1'b1;
        tick();
        kif.replay = 1'b0;
        n_cmp++; if (kif.rk_valid !== 1'b1 || kif.rk_round !== 4'd10 || kif.rk_data !== exp_rk[10]) begin n_err++; $display("FAIL replay_first got v%b %0d %h want v1 10 %h", kif.rk_valid, kif.rk_round, kif.rk_data, exp_rk[10]); end
        collect(30, -1, 0, '0);
        n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL replay_count got %0d want 11", cap_d.size()); end
        for (int i = 0; i < cap_d.size() && i < 11; i++) begin
            n_cmp++; if (cap_d[i] !== exp_rk[10-i] || cap_r[i] !== 4'(10-i)) begin n_err++; $display("FAIL replay_stream[%0d] got %0d %h want %0d %h", i, cap_r[i], cap_d[i], 10-i, exp_rk[10-i]); end
        end
        kif_nc.rk_ready   = 1'b1;
        kif_nc.cipher_key = FIPS_KEY;
        kif_nc.key_valid  = 1'b1;
        tick();
        kif_nc.key_valid  = 1'b0;
        w = 0;
        while (busy_nc && w < 40) begin tick(); w++; end
        n_cmp++; if (busy_nc !== 1'b0) begin n_err++; $display("FAIL nocache_drain got busy %b want 0", busy_nc); end
        kif_nc.replay = 1'b1;
        tick();
        kif_nc.replay = 1'b0;
        n_cmp++; if (kif_nc.rk_valid !== 1'b0 || kif_nc.key_ready !== 1'b1 || busy_nc !== 1'b0) begin n_err++; $display("FAIL nocache_replay got valid %b ready %b busy %b want 0 1 0", kif_nc.rk_valid, kif_nc.key_ready, busy_nc); end
        tick();
        n_cmp++; if (kif_nc.key_ready !== 1'b1) begin n_err++; $display("FAIL nocache_ready got %b want 1", kif_nc.key_ready); end
    endtask

    task automatic test_ignore();
        int e;
        logic [127:0] ka = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] kb = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] kc = {$urandom, $urandom, $urandom, $urandom};
        model_expand(ka);
        load_key(ka, 1'b0);
        kif.cipher_key = kb;
        kif.key_valid  = 1'b1;
        kif.replay     = 1'b1;
        repeat (4) tick();
        kif.key_valid  = 1'b0;
        kif.replay     = 1'b0;
        wait_valid(e);
        n_cmp++; if (e != 6) begin n_err++; $display("FAIL ignore_latency got %0d edges want 6", e); end
        collect(20, -1, 1, kb);
        n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL ignore_count got %0d want 11", cap_d.size()); end
        for (int i = 0; i < cap_d.size() && i < 11; i++) begin
            n_cmp++; if (cap_d[i] !== exp_rk[10-i] || cap_r[i] !== 4'(10-i)) begin n_err++; $display("FAIL ignore_stream[%0d] got %0d %h want %0d %h", i, cap_r[i], cap_d[i], 10-i, exp_rk[10-i]); end
        end
        n_cmp++; if (cap_dones != 1 || busy !== 1'b0) begin n_err++; $display("FAIL ignore_done got %0d pulses busy %b want 1 0", cap_dones, busy); end
        model_expand(kc);
        load_key(kc, 1'b1);
        wait_valid(e);
        n_cmp++; if (e != 10) begin n_err++; $display("FAIL load_replay_latency got %0d want 10", e); end
        collect(0, -1, 0, '0);
        n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL load_replay_count got %0d want 11", cap_d.size()); end
        for (int i = 0; i < cap_d.size() && i < 11; i++) begin
            n_cmp++; if (cap_d[i] !== exp_rk[10-i]) begin n_err++; $display("FAIL load_replay_stream[%0d] got %h want %h", i, cap_d[i], exp_rk[10-i]); end
        end
        kif.replay = 1'b1;
        tick();
        kif.replay = 1'b0;
        n_cmp++; if (kif.rk_valid !== 1'b1 || kif.rk_data !== exp_rk[10]) begin n_err++; $display("FAIL cache_overwrite got v%b %h want v1 %h", kif.rk_valid, kif.rk_data, exp_rk[10]); end
        collect(0, -1, 0, '0);
    endtask

    task automatic test_reset_abort();
        int e;
        logic [127:0] kd = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] ke = {$urandom, $urandom, $urandom, $urandom};
        load_key(kd, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({kif.key_ready, kif.rk_valid, busy, done, cache_valid} !== 5'b10000 || kif.rk_data !== 128'h0 || kif.rk_round !== 4'd0) begin n_err++; $display("FAIL abort_expand got ready/valid/busy/done/cache %b data %h round %0d want 10000 0 0", {kif.key_ready, kif.rk_valid, busy, done, cache_valid}, kif.rk_data, kif.rk_round); end
        model_expand(kd);
        load_key(kd, 1'b0);
        wait_valid(e);
        collect(0, 4, 0, '0);
        n_cmp++; if (cap_d.size() != 6 || kif.rk_round !== 4'd4 || kif.rk_data !== exp_rk[4]) begin n_err++; $display("FAIL abort_prefix got %0d keys showing %0d %h want 6 4 %h", cap_d.size(), kif.rk_round, kif.rk_data, exp_rk[4]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({kif.key_ready, kif.rk_valid, busy, done, cache_valid} !== 5'b10000 || kif.rk_data !== 128'h0 || kif.rk_round !== 4'd0) begin n_err++; $display("FAIL abort_stream got ready/valid/busy/done/cache %b data %h round %0d want 10000 0 0", {kif.key_ready, kif.rk_valid, busy, done, cache_valid}, kif.rk_data, kif.rk_round); end
        tick();
        n_cmp++; if (done !== 1'b0 || kif.rk_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_done got done %b valid %b want 0 0", done, kif.rk_valid); end
        model_expand(ke);
        load_key(ke, 1'b0);
        wait_valid(e);
        n_cmp++; if (e != 10) begin n_err++; $display("FAIL abort_reload_latency got %0d want 10", e); end
        collect(25, -1, 0, '0);
        n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL abort_reload_count got %0d want 11", cap_d.size()); end
        for (int i = 0; i < cap_d.size() && i < 11; i++) begin
            n_cmp++; if (cap_d[i] !== exp_rk[10-i]) begin n_err++; $display("FAIL abort_reload_stream[%0d] got %h want %h", i, cap_d[i], exp_rk[10-i]); end
        end
    endtask

    task automatic test_zero_key();
        int e;
        model_expand(128'h0);
        load_key(128'h0, 1'b0);
        wait_valid(e);
        n_cmp++; if (kif.rk_data !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_err++; $display("FAIL zero_round10 got %h want b4ef5bcb3e92e21123e951cf6f8f188e", kif.rk_data); end
        collect(40, -1, 0, '0);
        n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL zero_count got %0d want 11", cap_d.size()); end
        for (int i = 0; i < cap_d.size() && i < 11; i++) begin
            n_cmp++; if (cap_d[i] !== exp_rk[10-i] || cap_r[i] !== 4'(10-i)) begin n_err++; $display("FAIL zero_stream[%0d] got %0d %h want %0d %h", i, cap_r[i], cap_d[i], 10-i, exp_rk[10-i]); end
        end
        n_cmp++; if (cap_dones != 1) begin n_err++; $display("FAIL zero_done got %0d want 1", cap_dones); end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [127:0] k;
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            load_key(k, 1'b0);
            wait_valid(e);
            n_cmp++; if (e != 10) begin n_err++; $display("FAIL b2b_latency[%0d] got %0d want 10", n, e); end
            collect(n * 20, -1, 0, '0);
            n_cmp++; if (cap_d.size() != 11) begin n_err++; $display("FAIL b2b_count[%0d] got %0d want 11", n, cap_d.size()); end
            for (int i = 0; i < cap_d.size() && i < 11; i++) begin
                n_cmp++; if (cap_d[i] !== exp_rk[10-i] || cap_r[i] !== 4'(10-i)) begin n_err++; $display("FAIL b2b_stream[%0d][%0d] got %0d %h want %0d %h", n, i, cap_r[i], cap_d[i], 10-i, exp_rk[10-i]); end
            end
            n_cmp++; if (cap_dones != 1 || cap_unstable != 0) begin n_err++; $display("FAIL b2b_done_hold[%0d] got %0d pulses %0d unstable want 1 0", n, cap_dones, cap_unstable); end
        end
    endtask

    initial begin
        rst = 1'b1;
        kif.key_valid = 1'b0; kif.cipher_key = '0; kif.replay = 1'b0; kif.rk_ready = 1'b0;
        kif_nc.key_valid = 1'b0; kif_nc.cipher_key = '0; kif_nc.replay = 1'b0; kif_nc.rk_ready = 1'b0;
        init_ref_sbox();
        test_reset();
        test_fips();
        test_stall();
        test_replay();
        test_ignore();
        test_reset_abort();
        test_zero_key();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
